// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops, iterative shift-add multiply and restoring divide.
// Result and a one-cycle done pulse follow acceptance by 1 cycle (WIDTH+1 for mul/div/rem); start is ignored while busy.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CTRLW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [CTRLW-1:0] ALUControl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [CTRLW-1:0] OP_ADD  = CTRLW'(0);
    localparam logic [CTRLW-1:0] OP_SUB  = CTRLW'(1);
    localparam logic [CTRLW-1:0] OP_AND  = CTRLW'(2);
    localparam logic [CTRLW-1:0] OP_OR   = CTRLW'(3);
    localparam logic [CTRLW-1:0] OP_XOR  = CTRLW'(4);
    localparam logic [CTRLW-1:0] OP_SLT  = CTRLW'(5);
    localparam logic [CTRLW-1:0] OP_SLTU = CTRLW'(6);
    localparam logic [CTRLW-1:0] OP_SLL  = CTRLW'(7);
    localparam logic [CTRLW-1:0] OP_SRL  = CTRLW'(8);
    localparam logic [CTRLW-1:0] OP_SRA  = CTRLW'(9);
    localparam logic [CTRLW-1:0] OP_MUL  = CTRLW'(10);
    localparam logic [CTRLW-1:0] OP_DIV  = CTRLW'(11);
    localparam logic [CTRLW-1:0] OP_REM  = CTRLW'(12);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [CTRLW-1:0] r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_res;

    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_res;

    assign w_a_abs  = srcA[WIDTH-1] ? -srcA : srcA;
    assign w_b_abs  = srcB[WIDTH-1] ? -srcB : srcB;
    // During DIV, r_a shifts the dividend out MSB-first while collecting quotient bits in its LSB.
    assign w_rem_sh = {r_acc, r_a[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_b};
    assign w_shamt  = r_b[SHW-1:0];
    assign w_quo    = r_neg_q ? -r_a : r_a;
    assign w_rem    = r_neg_r ? -r_acc : r_acc;

    always_comb begin
        w_res = '0;
        case (r_op)
            OP_ADD:  w_res = r_a + r_b;
            OP_SUB:  w_res = r_a - r_b;
            OP_AND:  w_res = r_a & r_b;
            OP_OR:   w_res = r_a | r_b;
            OP_XOR:  w_res = r_a ^ r_b;
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (r_a < r_b)};
            OP_SLL:  w_res = r_a << w_shamt;
            OP_SRL:  w_res = r_a >> w_shamt;
            OP_SRA:  w_res = $signed(r_a) >>> w_shamt;
            OP_MUL:  w_res = r_acc;
            // A zero divisor leaves an all-ones quotient magnitude; force it so the sign fixup cannot disturb it.
            OP_DIV:  w_res = (r_b == '0) ? '1 : w_quo;
            OP_REM:  w_res = w_rem;
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_res   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op   <= ALUControl;
                        r_cnt  <= '0;
                        r_acc  <= '0;
                        r_busy <= 1'b1;
                        if (ALUControl == OP_DIV || ALUControl == OP_REM) begin
                            r_a     <= w_a_abs;
                            r_b     <= w_b_abs;
                            r_neg_q <= srcA[WIDTH-1] ^ srcB[WIDTH-1];
                            r_neg_r <= srcA[WIDTH-1];
                            r_state <= S_DIV;
                        end else begin
                            r_a     <= srcA;
                            r_b     <= srcB;
                            r_state <= (ALUControl == OP_MUL) ? S_MUL : S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    if (r_b[0]) begin
                        r_acc <= r_acc + r_a;
                    end
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == SHW'(WIDTH-1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (!w_diff[WIDTH]) begin
                        r_acc <= w_diff[WIDTH-1:0];
                        r_a   <= {r_a[WIDTH-2:0], 1'b1};
                    end else begin
                        r_acc <= w_rem_sh[WIDTH-1:0];
                        r_a   <= {r_a[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == SHW'(WIDTH-1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_res   <= w_res;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign ALUResult = r_res;
    assign zero      = (r_res == '0);

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: hand-computed vectors, latency, busy/done handshake, start blocking and reset abort.
module tb_seq_alu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [3:0]  ALUControl;
    logic        busy;
    logic        done;
    logic [31:0] ALUResult;
    logic        zero;

    int checks;
    int failures;

    seq_alu #(.WIDTH(32), .CTRLW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .srcA       (srcA),
        .srcB       (srcB),
        .ALUControl (ALUControl),
        .busy       (busy),
        .done       (done),
        .ALUResult  (ALUResult),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one operation, scrambles the inputs after acceptance, then measures latency and result.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        int busy_low;
        logic [31:0] res;
        logic        zf;
        @(negedge clk);
        start = 1'b1; ALUControl = op; srcA = a; srcB = b;
        @(negedge clk);
        start = 1'b0; srcA = $urandom; srcB = $urandom; ALUControl = 4'd13;
        lat = 0;
        busy_low = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy !== 1'b1) busy_low++;
            @(negedge clk);
            lat++;
        end
        res = ALUResult;
        zf  = zero;
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, res, exp);
        chk({tag, "_zero"}, {31'd0, zf}, {31'd0, (exp == 32'd0)});
        chk({tag, "_busy"}, busy_low, 0);
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_hold"}, ALUResult, exp);
    endtask

    initial begin
        int ndone;
        int got_lat;
        logic [31:0] got_res;

        checks = 0;
        failures = 0;
        rst = 1'b1; start = 1'b1; srcA = 32'd1; srcB = 32'd1; ALUControl = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_res", ALUResult, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        rst = 1'b0; start = 1'b0;

        run_op("add_wrap", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1);
        run_op("sub_zero", 4'd1, 32'd5, 32'd5, 32'h0000_0000, 1);
        run_op("and", 4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1);
        run_op("or", 4'd3, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1);
        run_op("xor", 4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1);
        run_op("slt", 4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1);
        run_op("sltu", 4'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
        run_op("sll", 4'd7, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 1);
        run_op("srl", 4'd8, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1);
        run_op("sra", 4'd9, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1);
        run_op("op13", 4'd13, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1);
        run_op("mul_neg", 4'd10, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 33);
        run_op("mul_mod", 4'd10, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33);
        run_op("div_neg", 4'd11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
        run_op("rem_neg", 4'd12, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        run_op("div_by0", 4'd11, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 33);
        run_op("rem_by0", 4'd12, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 33);
        run_op("div_ovf", 4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        run_op("rem_ovf", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("div_pos", 4'd11, 32'd100, 32'd7, 32'd14, 33);
        run_op("rem_mix", 4'd12, 32'd100, 32'hFFFF_FFF9, 32'd2, 33);

        // Start pulses mid-multiply and during the final busy cycle must both be dropped.
        @(negedge clk);
        start = 1'b1; ALUControl = 4'd10; srcA = 32'hFFFF_FFFD; srcB = 32'd7;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; got_lat = -1; got_res = 32'd0;
        for (int c = 1; c <= 75; c++) begin
            if (c == 6 || c == 33) begin
                start = 1'b1; ALUControl = 4'd10; srcA = 32'd100; srcB = 32'd100;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (got_lat < 0) begin
                    got_lat = c;
                    got_res = ALUResult;
                end
            end
        end
        start = 1'b0;
        chk("ignore_ndone", ndone, 1);
        chk("ignore_lat", got_lat, 33);
        chk("ignore_res", got_res, 32'hFFFF_FFEB);

        // start held high: one accepted add every two cycles.
        @(negedge clk);
        start = 1'b1; ALUControl = 4'd0; srcA = 32'd1; srcB = 32'd2;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        start = 1'b0;
        chk("b2b_ndone", ndone, 10);
        chk("b2b_res", ALUResult, 32'd3);
        repeat (3) @(negedge clk);

        // Reset ten cycles into a divide aborts it silently.
        @(negedge clk);
        start = 1'b1; ALUControl = 4'd11; srcA = 32'd1000; srcB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_res", ALUResult, 32'd0);
        chk("abort_zero", {31'd0, zero}, 32'd1);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("abort_ndone", ndone, 0);
        run_op("post_rst_add", 4'd0, 32'd2, 32'd3, 32'd5, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
